// File: rtl/counter_pkg.sv
// Shared definitions for the packed-BCD counter: digit geometry, the
// packed-BCD word type and the single-digit step helpers used to build
// the carry/borrow chain.
package counter_pkg;

    localparam int unsigned BCD_DIGITS    = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam int unsigned BCD_WIDTH     = 16;

    // Four BCD digits, digit 3 in the top nibble.
    typedef logic [BCD_WIDTH-1:0] bcd_word_t;

    // Result of stepping one BCD digit: new digit plus carry/borrow out.
    typedef struct packed {
        logic [3:0] digit;
        logic       cout;
    } bcd_step_t;

    // Increment one digit when cin is set; a 9 rolls to 0 and carries.
    function automatic bcd_step_t bcd_digit_up(input logic [3:0] digit, input logic cin);
        bcd_step_t res;
        if (!cin) begin
            res.digit = digit;
            res.cout  = 1'b0;
        end else if (digit == BCD_MAX_DIGIT) begin
            res.digit = 4'd0;
            res.cout  = 1'b1;
        end else begin
            res.digit = digit + 4'd1;
            res.cout  = 1'b0;
        end
        return res;
    endfunction

    // Decrement one digit when bin is set; a 0 rolls to 9 and borrows.
    function automatic bcd_step_t bcd_digit_down(input logic [3:0] digit, input logic bin);
        bcd_step_t res;
        if (!bin) begin
            res.digit = digit;
            res.cout  = 1'b0;
        end else if (digit == 4'd0) begin
            res.digit = BCD_MAX_DIGIT;
            res.cout  = 1'b1;
        end else begin
            res.digit = digit - 4'd1;
            res.cout  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_count_source_if.sv
// Button/enable inputs and BCD count outputs of the counter, bundled so the
// display side and the button side can be wired as one connection.
interface bcd_count_source_if;
    import counter_pkg::*;

    logic      btn_up;
    logic      btn_down;
    logic      btn_clr;
    logic      en;
    bcd_word_t count;
    logic      wrap;

    // Driver of the buttons / consumer of the count.
    modport master (
        output btn_up,
        output btn_down,
        output btn_clr,
        output en,
        input  count,
        input  wrap
    );

    // The counter itself.
    modport slave (
        input  btn_up,
        input  btn_down,
        input  btn_clr,
        input  en,
        output count,
        output wrap
    );

endinterface

// File: rtl/debounce_pulse.sv
// One raw push-button: two-flop synchronizer, stability filter and
// rising-edge detector. A press produces exactly one single-cycle pulse
// once the synchronized level has held for DEBOUNCE_CYCLES samples.
module debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic inc,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    // Filter terminal count; the level is accepted on the sample where the
    // counter already shows DEBOUNCE_CYCLES-1 differing samples.
    localparam logic [19:0] DCNT_LAST = 20'(DEBOUNCE_CYCLES - 32'd1);

    logic        r_s1;
    logic        r_s2;
    logic        r_stable;
    logic        r_stable_q;
    logic [19:0] r_dcnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge inc or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after it persists; any return to the
    // accepted level restarts the count.
    always_ff @(posedge inc or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_dcnt   <= 20'd0;
        end else if (r_s2 == r_stable) begin
            r_dcnt   <= 20'd0;
        end else if (r_dcnt == DCNT_LAST) begin
            r_stable <= r_s2;
            r_dcnt   <= 20'd0;
        end else begin
            r_dcnt   <= r_dcnt + 20'd1;
        end
    end

    // Delayed copy of the accepted level for rising-edge detection.
    always_ff @(posedge inc or posedge reset) begin
        if (reset) begin
            r_stable_q <= 1'b0;
        end else begin
            r_stable_q <= r_stable;
        end
    end

    // High for the single cycle after the accepted level rises; releases
    // produce nothing.
    assign pulse = r_stable & ~r_stable_q;

endmodule

// File: rtl/bcd_count_source.sv
// Four-digit packed-BCD up/down counter fed by three debounced buttons.
// Clear has top priority, simultaneous up+down cancels, and steps are
// gated by en. Count and wrap are registered.
module bcd_count_source
    import counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic               inc,
    input  logic               reset,
    bcd_count_source_if.slave  bus
);

    logic      w_up_pulse;
    logic      w_down_pulse;
    logic      w_clr_pulse;

    bcd_word_t w_inc_word;
    logic      w_inc_wrap;
    bcd_word_t w_dec_word;
    logic      w_dec_wrap;

    bcd_word_t w_count_next;
    logic      w_wrap_next;

    bcd_word_t r_count;
    logic      r_wrap;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .inc   (inc),
        .reset (reset),
        .raw   (bus.btn_up),
        .pulse (w_up_pulse)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .inc   (inc),
        .reset (reset),
        .raw   (bus.btn_down),
        .pulse (w_down_pulse)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .inc   (inc),
        .reset (reset),
        .raw   (bus.btn_clr),
        .pulse (w_clr_pulse)
    );

    // Ripple a +1 through the digits; carry out of the top digit is a wrap.
    always_comb begin : p_inc_chain
        logic      l_carry;
        bcd_step_t l_step;
        w_inc_word = 16'h0000;
        l_carry    = 1'b1;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            l_step              = bcd_digit_up(r_count[4*i +: 4], l_carry);
            w_inc_word[4*i +: 4] = l_step.digit;
            l_carry             = l_step.cout;
        end
        w_inc_wrap = l_carry;
    end

    // Ripple a -1 through the digits; borrow out of the top digit is a wrap.
    always_comb begin : p_dec_chain
        logic      l_borrow;
        bcd_step_t l_step;
        w_dec_word = 16'h0000;
        l_borrow   = 1'b1;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            l_step              = bcd_digit_down(r_count[4*i +: 4], l_borrow);
            w_dec_word[4*i +: 4] = l_step.digit;
            l_borrow            = l_step.cout;
        end
        w_dec_wrap = l_borrow;
    end

    // Priority select of the next count: clear, cancel, up, down, hold.
    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (w_clr_pulse) begin
            w_count_next = 16'h0000;
            w_wrap_next  = 1'b0;
        end else if (w_up_pulse && w_down_pulse) begin
            w_count_next = r_count;
            w_wrap_next  = 1'b0;
        end else if (w_up_pulse && bus.en) begin
            w_count_next = w_inc_word;
            w_wrap_next  = w_inc_wrap;
        end else if (w_down_pulse && bus.en) begin
            w_count_next = w_dec_word;
            w_wrap_next  = w_dec_wrap;
        end else begin
            w_count_next = r_count;
            w_wrap_next  = 1'b0;
        end
    end

    // Output registers; wrap is rewritten every cycle so it is a one-cycle pulse.
    always_ff @(posedge inc or posedge reset) begin
        if (reset) begin
            r_count <= 16'h0000;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.count = r_count;
    assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_bcd_count_source.sv
// Bench for bcd_count_source with a short debounce window: exact press
// latency, table of press vectors, BCD carry/wrap corners, glitch
// rejection, priority cases, reset mid-debounce, and random presses
// checked against an integer reference model.
module tb_bcd_count_source;

    localparam int DC   = 4;
    localparam int HOLD = DC + 4;

    logic inc = 1'b0;
    logic reset;

    always #5 inc = ~inc;

    bcd_count_source_if bus();

    bcd_count_source #(.DEBOUNCE_CYCLES(DC)) dut (
        .inc   (inc),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int model = 0;

    typedef struct {
        logic        u;
        logic        d;
        logic        c;
        logic        e;
        logic [15:0] exp_count;
        int          exp_wraps;
    } vec_t;

    vec_t tbl [14];

    // Integer 0..9999 to packed BCD by plain decimal division.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clean press and release; counts wrap-high cycles throughout.
    task automatic press(input logic u, input logic d, input logic c, input logic e,
                         output int wraps, output logic [15:0] cnt);
        @(negedge inc);
        bus.btn_up   = u;
        bus.btn_down = d;
        bus.btn_clr  = c;
        bus.en       = e;
        wraps = 0;
        repeat (HOLD) begin
            @(negedge inc);
            if (bus.wrap === 1'b1) wraps++;
        end
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_clr  = 1'b0;
        repeat (HOLD) begin
            @(negedge inc);
            if (bus.wrap === 1'b1) wraps++;
        end
        bus.en = 1'b1;
        cnt = bus.count;
    endtask

    // Press, advance the reference model, and compare count and wraps.
    task automatic mpress(input string name, input logic u, input logic d, input logic c, input logic e);
        int          w;
        int          exp_w;
        logic [15:0] cnt;
        press(u, d, c, e, w, cnt);
        exp_w = 0;
        if (c) begin
            model = 0;
        end else if (u && d) begin
            exp_w = 0;
        end else if (u && e) begin
            exp_w = (model == 9999) ? 1 : 0;
            model = (model + 1) % 10000;
        end else if (d && e) begin
            exp_w = (model == 0) ? 1 : 0;
            model = (model + 9999) % 10000;
        end
        chk16({name, "_count"}, cnt, to_bcd(model));
        chk_int({name, "_wrap"}, w, exp_w);
    endtask

    initial begin
        int          w;
        logic [15:0] cnt;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h9999, 1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 0};

        reset        = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_clr  = 1'b0;
        bus.en       = 1'b1;
        repeat (3) @(negedge inc);
        chk16("reset_count", bus.count, 16'h0000);
        chk_int("reset_wrap", int'(bus.wrap), 0);
        reset = 1'b0;
        repeat (50) @(negedge inc);
        chk16("idle_count", bus.count, 16'h0000);
        chk_int("idle_wrap", int'(bus.wrap), 0);

        // Held button: step lands exactly six edges after first sample.
        @(negedge inc);
        bus.btn_up = 1'b1;
        repeat (6) @(negedge inc);
        chk16("latency_before", bus.count, 16'h0000);
        @(negedge inc);
        chk16("latency_at", bus.count, 16'h0001);
        repeat (20) @(negedge inc);
        chk16("held_no_repeat", bus.count, 16'h0001);
        bus.btn_up = 1'b0;
        repeat (HOLD) @(negedge inc);

        press(1'b0, 1'b0, 1'b1, 1'b1, w, cnt);
        chk16("clr_before_table", cnt, 16'h0000);

        for (int i = 0; i < 14; i++) begin
            press(tbl[i].u, tbl[i].d, tbl[i].c, tbl[i].e, w, cnt);
            chk16($sformatf("tbl%0d_count", i), cnt, tbl[i].exp_count);
            chk_int($sformatf("tbl%0d_wrap", i), w, tbl[i].exp_wraps);
        end
        model = 0;

        // Digit carries: 0000 -> 0010 -> 0099 -> 0100.
        for (int i = 0; i < 10; i++) mpress("up10", 1'b1, 1'b0, 1'b0, 1'b1);
        chk16("reach_0010", bus.count, 16'h0010);
        for (int i = 0; i < 89; i++) mpress("up99", 1'b1, 1'b0, 1'b0, 1'b1);
        chk16("reach_0099", bus.count, 16'h0099);
        press(1'b1, 1'b0, 1'b0, 1'b1, w, cnt);
        chk16("carry_0100", cnt, 16'h0100);
        chk_int("carry_0100_wrap", w, 0);
        model = 100;

        // Short glitches never reach acceptance.
        for (int k = 0; k < 5; k++) begin
            @(negedge inc);
            bus.btn_up = 1'b1;
            repeat (3) @(negedge inc);
            bus.btn_up = 1'b0;
            repeat (3) @(negedge inc);
        end
        repeat (10) @(negedge inc);
        chk16("glitch_unchanged", bus.count, 16'h0100);

        mpress("en_low", 1'b1, 1'b0, 1'b0, 1'b0);
        chk16("en_low_const", bus.count, 16'h0100);

        mpress("clr42", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 42; i++) mpress("up42", 1'b1, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0, 1'b1, w, cnt);
        chk16("updown_cancel", cnt, 16'h0042);
        press(1'b1, 1'b0, 1'b1, 1'b1, w, cnt);
        chk16("clr_with_up", cnt, 16'h0000);
        chk_int("clr_with_up_wrap", w, 0);
        model = 0;

        // Random presses against the integer model.
        for (int i = 0; i < 150; i++) begin
            logic ru, rd, rc, re;
            ru = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 7) == 0);
            re = ($urandom_range(0, 4) != 0);
            mpress($sformatf("rnd%0d", i), ru, rd, rc, re);
        end

        // Reset in the middle of a debounce discards the partial press.
        mpress("pre_rst_clr", 1'b0, 1'b0, 1'b1, 1'b1);
        mpress("pre_rst_up", 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge inc);
        bus.btn_up = 1'b1;
        repeat (3) @(negedge inc);
        reset = 1'b1;
        #1;
        chk16("async_reset_count", bus.count, 16'h0000);
        repeat (2) @(negedge inc);
        reset = 1'b0;
        repeat (6) @(negedge inc);
        chk16("rst_restart_before", bus.count, 16'h0000);
        @(negedge inc);
        chk16("rst_restart_at", bus.count, 16'h0001);
        repeat (20) @(negedge inc);
        chk16("rst_restart_once", bus.count, 16'h0001);
        bus.btn_up = 1'b0;
        repeat (HOLD) @(negedge inc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
